note_match_judge: RTL and testbench
===================================

// Module: note_match_judge
// PURPOSE
// - Learning-mode front end for the auto-play music block: debounces the 7 note keys, judges each
//   press against the note code currently being presented, and drives that block's isMatch input.
// - Also keeps hit/miss counters for the seven-segment score display.
// - Note code format is the 6-bit melody code: 0 = rest; otherwise note = ((code-1)%7)+1 (do..si)
//   and group = (code-1)/7, where groups 0-2 are mid, 3-5 are low and 6-8 are high.
// PARAMETERS
// - DEB_CYC      2_000_000  clk cycles a key vector must stay stable before it is accepted (20 ms)
// - TIMEOUT_CYC  300_000_000  cycles in WAIT without a correct press before a miss is counted (3 s)
// - CNT_W        8          width of hit_cnt/miss_cnt
// PORTS
// - clk          in   1      system clock
// - rst          in   1      synchronous, active-high reset
// - en           in   1      learning mode enabled (0 = auto mode; judge is idle)
// - note_strobe  in   1      1-cycle pulse; a new expected note is presented on note_code
// - note_code    in   6      expected melody code, sampled on note_strobe
// - keys_raw     in   7      raw note keys, bit6 = do ... bit0 = si (same order as the lights bus)
// - oct_high     in   1      raw octave-up switch
// - oct_low      in   1      raw octave-down switch
// - is_match     out  1      level to the player's isMatch input
// - hit_cnt      out  CNT_W  correct notes (saturating)
// - miss_cnt     out  CNT_W  wrong presses plus timeouts (saturating)
// - wrong        out  1      1-cycle pulse on each wrong press
// BEHAVIOUR
// - Reset: FSM in IDLE; is_match=0, wrong=0, hit_cnt=0, miss_cnt=0; debounce counter=0; stable keys=0.
// - Debounce: one shared counter over {keys_raw,oct_high,oct_low}.
//   - Any change of that vector from the previous cycle clears the counter.
//   - When the counter reaches DEB_CYC-1, the vector is copied to keys_stb (no further increment).
//   - A "press" is keys_stb going from 0 to nonzero; judging happens in the cycle after keys_stb updates.
// - FSM states: IDLE, WAIT, MATCH, WRONG.
//   - IDLE: is_match=0. If en=1 and note_strobe=1: latch note_code, clear timeout counter, go to WAIT.
//   - WAIT with latched code 0 (rest): go to MATCH the next cycle. No counter changes.
//   - WAIT, on a press:
//     - Correct when keys_stb[6:0] is one-hot AND its index equals the decoded note -> MATCH,
//       hit_cnt+1.
//     - Otherwise -> WRONG, miss_cnt+1, wrong pulses for 1 cycle.
//     - Multi-key presses are always wrong.
//   - WAIT, timeout counter reaches TIMEOUT_CYC-1: miss_cnt+1, counter restarts, stay in WAIT.
//   - MATCH: is_match=1, registered, asserted the cycle the FSM enters MATCH.
//     - Held until note_strobe; then latch the new code and go to WAIT, with is_match=0 that same cycle.
//   - WRONG: go back to WAIT once keys_stb==0 (release). A held wrong key never rescores.
// - note_strobe in WAIT or WRONG: relatch the code, clear the timeout counter, go to WAIT.
//   The old note is abandoned without a miss.
// - note_strobe in the same cycle as a judged press: the press is judged against the OLD code,
//   then the new code is latched and the FSM goes to WAIT.
// - en falling in any state: go to IDLE next cycle, is_match=0. Counters keep their values.
// - Counters saturate at 2^CNT_W-1. rst mid-note returns everything to the reset values next edge.
// CONFIGURATION
// - STRICT_OCTAVE_EN defined: "correct" also requires the octave to match.
//   - mid group needs oct_high=0 and oct_low=0; low group needs oct_low=1, oct_high=0;
//     high group needs oct_high=1, oct_low=0.
//   - A correct note name in the wrong octave is a wrong press.
// - Not defined: the octave switches are ignored for judging. They are still part of the debounced
//   vector, so toggling them restarts the debounce.
// TESTING (DEB_CYC=4, TIMEOUT_CYC=50)
// - rst, en=1, strobe code 6'd8 (do), keys_raw=7'b1000000 held 10 cycles
//   -> is_match=1 about 6 cycles after the key change, hit_cnt=1, miss_cnt=0.
// - Strobe code 6'd10 (mi), press 7'b0100000 (re), release, press 7'b0010000
//   -> wrong pulse once, miss_cnt=1, then is_match=1, hit_cnt=1.
// - Strobe code 6'd12, no keys for 120 cycles -> miss_cnt=2, is_match stays 0.
// - Strobe code 0 -> is_match=1 within 2 cycles, counters unchanged.
//   Then strobe with en dropped -> IDLE, is_match=0.
// - Glitch: keys_raw toggles every 2 cycles -> no press is registered and counters are unchanged.
//   Drive 300 hits -> hit_cnt saturates at 255.
// - STRICT_OCTAVE_EN: strobe code 6'd43 (do_high)
//   - do key with oct_high=0 -> wrong.
//   - do key with oct_high=1 -> is_match=1.
//   - Without the macro, the first press already matches.

Source files
------------

// File: rtl/note_match_judge.sv
// Purpose : learning-mode judge; debounces note keys + octave switches, scores each press
//           against the presented note code, drives is_match and saturating hit/miss counters.
// Latency : key change -> keys_stb after DEB_CYC+1 edges; verdict registered one edge later.
// Backpressure: none; note_strobe is always accepted (abandons the current note without a miss).
// Ports   : clk, rst (sync, active-high), en, note_strobe, note_code[5:0], keys_raw[6:0]
//           (bit6=do..bit0=si), oct_high, oct_low -> is_match, hit_cnt, miss_cnt, wrong (pulse).
// Config  : define STRICT_OCTAVE_EN to also require the octave switches to match the note group.
module note_match_judge #(
  parameter int DEB_CYC     = 2_000_000,
  parameter int TIMEOUT_CYC = 300_000_000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             note_strobe,
  input  logic [5:0]       note_code,
  input  logic [6:0]       keys_raw,
  input  logic             oct_high,
  input  logic             oct_low,
  output logic             is_match,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             wrong
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MATCH, S_WRONG} state_e;

  state_e           state_q, state_d;
  logic [5:0]       code_q, code_d;
  logic [8:0]       vec_prev_q, vec_prev_d;
  logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
  logic [8:0]       stb_q, stb_d;          // {keys[6:0], oct_high, oct_low}
  logic [6:0]       stb_prev_q, stb_prev_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
  logic             wrong_q, wrong_d;
  logic             is_match_q, is_match_d;

  logic [8:0] vec;
  logic       press;
  logic       correct;
  logic       oct_ok;
  logic       hit_inc, miss_inc;
  logic [5:0] code_m1;
  logic [2:0] note_idx;
  logic [5:0] grp;
  logic [6:0] exp_keys;

  assign vec = {keys_raw, oct_high, oct_low};

  // Shared debounce: counter restarts on any change and parks at its last value once stable.
  always_comb begin
    deb_cnt_d  = deb_cnt_q;
    stb_d      = stb_q;
    vec_prev_d = vec;
    stb_prev_d = stb_q[8:2];
    if (vec != vec_prev_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      stb_d = vec;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // A press is the debounced key field leaving all-zero; octave bits alone never press.
  assign press = (stb_prev_q == 7'd0) && (stb_q[8:2] != 7'd0);

  // Melody code decode: code-1 splits into note (mod 7) and group (div 7).
  assign code_m1  = code_q - 6'd1;
  assign note_idx = 3'(code_m1 % 6'd7);
  assign grp      = code_m1 / 6'd7;
  assign exp_keys = 7'(7'b1000000 >> note_idx);

`ifdef STRICT_OCTAVE_EN
  always_comb begin
    oct_ok = 1'b0;
    if (grp <= 6'd2)      oct_ok = !stb_q[1] && !stb_q[0];
    else if (grp <= 6'd5) oct_ok = !stb_q[1] &&  stb_q[0];
    else                  oct_ok =  stb_q[1] && !stb_q[0];
  end
`else
  // grp only matters for the strict-octave build.
  assign oct_ok = 1'b1 | (|grp);
`endif

  // exp_keys is one-hot, so equality also rejects multi-key presses.
  assign correct = (stb_q[8:2] == exp_keys) && oct_ok;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    tmo_d    = tmo_q;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    wrong_d  = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_WAIT: begin
          if (code_q == 6'd0) begin
            state_d = S_MATCH;
          end else if (press) begin
            if (correct) begin
              hit_inc = 1'b1;
              state_d = S_MATCH;
            end else begin
              miss_inc = 1'b1;
              wrong_d  = 1'b1;
              state_d  = S_WRONG;
            end
          end else if (tmo_q == TMO_LAST) begin
            miss_inc = 1'b1;
            tmo_d    = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_MATCH: ;
        S_WRONG: begin
          if (stb_q[8:2] == 7'd0) state_d = S_WAIT;
        end
        default: state_d = S_IDLE;
      endcase
      // A strobe in any state starts a fresh note; a press judged this cycle used the old code.
      if (note_strobe) begin
        code_d  = note_code;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
    end
  end

  assign is_match_d = (state_d == S_MATCH);
  assign hit_d  = (hit_inc  && (hit_q  != '1)) ? hit_q  + 1'b1 : hit_q;
  assign miss_d = (miss_inc && (miss_q != '1)) ? miss_q + 1'b1 : miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      vec_prev_q <= '0;
      deb_cnt_q  <= '0;
      stb_q      <= '0;
      stb_prev_q <= '0;
      tmo_q      <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      wrong_q    <= 1'b0;
      is_match_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      vec_prev_q <= vec_prev_d;
      deb_cnt_q  <= deb_cnt_d;
      stb_q      <= stb_d;
      stb_prev_q <= stb_prev_d;
      tmo_q      <= tmo_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      wrong_q    <= wrong_d;
      is_match_q <= is_match_d;
    end
  end

  assign is_match = is_match_q;
  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
  assign wrong    = wrong_q;

endmodule

// File: tb/tb_note_match_judge.sv
// Purpose : directed self-checking bench for note_match_judge (DEB_CYC=4, TIMEOUT_CYC=50).
// Latency : inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpressure: not applicable.
module tb_note_match_judge;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, en, note_strobe, oct_high, oct_low;
  logic [5:0]       note_code;
  logic [6:0]       keys_raw;
  logic             is_match, wrong;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;
  int wrong_cnt = 0;
  int wrong_run = 0;
  int wrong_max = 0;
  int lat;
  int w0;

  always #5 clk = ~clk;

  note_match_judge #(.DEB_CYC(4), .TIMEOUT_CYC(50), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .note_strobe(note_strobe), .note_code(note_code),
    .keys_raw(keys_raw), .oct_high(oct_high), .oct_low(oct_low),
    .is_match(is_match), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wrong(wrong)
  );

  always @(negedge clk) begin
    if (wrong) begin
      wrong_cnt++;
      wrong_run++;
      if (wrong_run > wrong_max) wrong_max = wrong_run;
    end else begin
      wrong_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [5:0] c);
    note_code   = c;
    note_strobe = 1'b1;
    tick(1);
    note_strobe = 1'b0;
  endtask

  // Edges until is_match rises after the caller's last stimulus change; 0 if it never does.
  task automatic wait_match(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      tick(1);
      if (is_match) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; note_strobe = 1'b0; note_code = 6'd0;
    keys_raw = 7'd0; oct_high = 1'b0; oct_low = 1'b0;
    #1;
    do_reset();
    check("rst_is_match", 32'(is_match), 0);
    check("rst_wrong",    32'(wrong),    0);
    check("rst_hit",      32'(hit_cnt),  0);
    check("rst_miss",     32'(miss_cnt), 0);

    // Correct press of do on code 8.
    strobe(6'd8);
    keys_raw = 7'b1000000;
    wait_match(20, lat);
    check("hit_latency", 32'(lat), 6);
    tick(4);
    check("hit_is_match", 32'(is_match), 1);
    check("hit_hit",      32'(hit_cnt),  1);
    check("hit_miss",     32'(miss_cnt), 0);
    keys_raw = 7'd0;
    tick(8);

    // Wrong (re) then correct (mi) on code 10.
    do_reset();
    w0 = wrong_cnt;
    strobe(6'd10);
    keys_raw = 7'b0100000;
    tick(8);
    check("wr_miss",     32'(miss_cnt),       1);
    check("wr_pulses",   32'(wrong_cnt - w0), 1);
    check("wr_is_match", 32'(is_match),       0);
    keys_raw = 7'd0;
    tick(8);
    keys_raw = 7'b0010000;
    tick(8);
    check("wr_fix_is_match", 32'(is_match),       1);
    check("wr_fix_hit",      32'(hit_cnt),        1);
    check("wr_fix_miss",     32'(miss_cnt),       1);
    check("wr_fix_pulses",   32'(wrong_cnt - w0), 1);
    keys_raw = 7'd0;
    tick(8);

    // Timeouts: two misses in 120 cycles with no keys.
    do_reset();
    strobe(6'd12);
    tick(120);
    check("tmo_miss",     32'(miss_cnt), 2);
    check("tmo_hit",      32'(hit_cnt),  0);
    check("tmo_is_match", 32'(is_match), 0);

    // Rest note matches on its own.
    strobe(6'd0);
    wait_match(5, lat);
    check("rest_within2", 32'((lat >= 1) && (lat <= 2)), 1);
    check("rest_miss",    32'(miss_cnt), 2);
    check("rest_hit",     32'(hit_cnt),  0);

    // en dropped: IDLE, no matching, no timeouts, counters kept.
    en = 1'b0;
    strobe(6'd12);
    check("en_off_is_match", 32'(is_match), 0);
    en = 1'b1;
    tick(60);
    check("idle_is_match", 32'(is_match), 0);
    check("idle_miss",     32'(miss_cnt), 2);

    // Glitching key never becomes a press; a clean press afterwards does.
    do_reset();
    w0 = wrong_cnt;
    strobe(6'd8);
    for (int i = 0; i < 8; i++) begin
      keys_raw = 7'b1000000;
      tick(2);
      keys_raw = 7'd0;
      tick(2);
    end
    tick(6);
    check("glitch_hit",      32'(hit_cnt),        0);
    check("glitch_miss",     32'(miss_cnt),       0);
    check("glitch_is_match", 32'(is_match),       0);
    check("glitch_pulses",   32'(wrong_cnt - w0), 0);
    keys_raw = 7'b1000000;
    tick(8);
    check("post_glitch_hit", 32'(hit_cnt), 1);
    keys_raw = 7'd0;
    tick(8);

    // Two keys at once is always wrong.
    do_reset();
    strobe(6'd8);
    keys_raw = 7'b1100000;
    tick(8);
    check("multi_miss",     32'(miss_cnt), 1);
    check("multi_hit",      32'(hit_cnt),  0);
    check("multi_is_match", 32'(is_match), 0);
    keys_raw = 7'd0;
    tick(8);

    // Octave handling on code 43 (high do).
    do_reset();
    strobe(6'd43);
    oct_high = 1'b0;
    keys_raw = 7'b1000000;
    tick(8);
`ifdef STRICT_OCTAVE_EN
    check("oct_low_sw_miss",     32'(miss_cnt), 1);
    check("oct_low_sw_is_match", 32'(is_match), 0);
    keys_raw = 7'd0;
    tick(8);
    oct_high = 1'b1;
    tick(8);
    keys_raw = 7'b1000000;
    tick(8);
    check("oct_high_is_match", 32'(is_match), 1);
    check("oct_high_hit",      32'(hit_cnt),  1);
`else
    check("oct_ignored_is_match", 32'(is_match), 1);
    check("oct_ignored_hit",      32'(hit_cnt),  1);
    check("oct_ignored_miss",     32'(miss_cnt), 0);
`endif
    keys_raw = 7'd0;
    oct_high = 1'b0;
    tick(8);

    // Saturation: 300 correct notes.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      strobe(6'd8);
      keys_raw = 7'b1000000;
      tick(7);
      keys_raw = 7'd0;
      tick(6);
    end
    check("sat_hit",      32'(hit_cnt),  255);
    check("sat_miss",     32'(miss_cnt), 0);
    check("sat_is_match", 32'(is_match), 1);

    // Reset while matched clears everything on the next edge.
    rst = 1'b1;
    tick(1);
    check("midrst_hit",      32'(hit_cnt),  0);
    check("midrst_is_match", 32'(is_match), 0);
    rst = 1'b0;
    tick(2);

    check("wrong_pulse_width", 32'(wrong_max), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
